// File: rtl/ls_buffer.sv
// In-order load/store queue: captures operands from the RSS and LSB result buses,
// performs one memory access at a time at the head, and keeps committed stores across a ROB flush.
module ls_buffer #(
  parameter int unsigned LSB_SIZE     = 16,
  parameter int unsigned ROB_ID_WIDTH = 4,
  parameter int unsigned XLEN         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  output logic                    is_ls_buffer_full,
  input  logic                    valid_from_issuer,
  input  logic                    is_store_from_issuer,
  input  logic [2:0]              funct3_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] qj_from_issuer,
  input  logic [XLEN-1:0]         vj_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] qk_from_issuer,
  input  logic [XLEN-1:0]         vk_from_issuer,
  input  logic [XLEN-1:0]         imm_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rob_bus,
  input  logic                    ls_select_from_rob_bus,
  input  logic                    reset_from_rob_bus,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rss_bus,
  input  logic [XLEN-1:0]         value_from_rss_bus,
  output logic [ROB_ID_WIDTH-1:0] dest_to_lsb_bus,
  output logic [XLEN-1:0]         value_to_lsb_bus,
  output logic                    mem_valid,
  output logic                    mem_write,
  output logic [XLEN-1:0]         mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  output logic [1:0]              mem_width,
  input  logic                    mem_done,
  input  logic [XLEN-1:0]         mem_rdata
);

  localparam int unsigned PW = $clog2(LSB_SIZE + 1);
  localparam logic [PW-1:0] SZ   = PW'(LSB_SIZE);
  localparam logic [PW:0]   SZ_X = (PW + 1)'(LSB_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_WAIT, S_STORE_WAIT, S_DRAIN} state_t;

  logic                    r_valid     [1:LSB_SIZE];
  logic                    r_is_store  [1:LSB_SIZE];
  logic                    r_committed [1:LSB_SIZE];
  logic                    r_go        [1:LSB_SIZE];
  logic [2:0]              r_funct3    [1:LSB_SIZE];
  logic [ROB_ID_WIDTH-1:0] r_dest      [1:LSB_SIZE];
  logic [ROB_ID_WIDTH-1:0] r_qj        [1:LSB_SIZE];
  logic [ROB_ID_WIDTH-1:0] r_qk        [1:LSB_SIZE];
  logic [XLEN-1:0]         r_vj        [1:LSB_SIZE];
  logic [XLEN-1:0]         r_vk        [1:LSB_SIZE];
  logic [XLEN-1:0]         r_imm       [1:LSB_SIZE];

  logic [PW-1:0] r_head, r_tail, r_size;
  state_t        r_state, w_next_state;

  logic              w_issue_load, w_issue_store, w_pop, w_bcast, w_enq;
  logic              w_head_load_ok, w_head_store_ok;
  logic [LSB_SIZE:1] w_keep;
  logic [PW-1:0]     w_kept, w_flush_tail;
  logic [PW:0]       w_tsum;
  logic              w_qj_hit, w_qk_hit;
  logic [XLEN-1:0]   w_enq_vj, w_enq_vk;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == SZ) ? PW'(1) : p + PW'(1);
  endfunction

  function automatic logic [XLEN-1:0] f_ext(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3)
      3'd0:    return {{(XLEN-8){d[7]}}, d[7:0]};
      3'd1:    return {{(XLEN-16){d[15]}}, d[15:0]};
      3'd4:    return {{(XLEN-8){1'b0}}, d[7:0]};
      3'd5:    return {{(XLEN-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign is_ls_buffer_full = (r_size >= PW'(LSB_SIZE - 1));
  assign w_enq = valid_from_issuer && !reset_from_rob_bus;

  // Operands already on a result bus during enqueue are captured as ready.
  assign w_qj_hit = (qj_from_issuer != '0) &&
                    (qj_from_issuer == dest_from_rss_bus || qj_from_issuer == dest_to_lsb_bus);
  assign w_qk_hit = (qk_from_issuer != '0) &&
                    (qk_from_issuer == dest_from_rss_bus || qk_from_issuer == dest_to_lsb_bus);
  assign w_enq_vj = !w_qj_hit ? vj_from_issuer :
                    (qj_from_issuer == dest_from_rss_bus) ? value_from_rss_bus : value_to_lsb_bus;
  assign w_enq_vk = !w_qk_hit ? vk_from_issuer :
                    (qk_from_issuer == dest_from_rss_bus) ? value_from_rss_bus : value_to_lsb_bus;

  assign w_head_load_ok  = r_valid[r_head] && !r_is_store[r_head] && r_go[r_head] &&
                           (r_qj[r_head] == '0) && !reset_from_rob_bus;
  assign w_head_store_ok = r_valid[r_head] && r_is_store[r_head] && r_committed[r_head] &&
                           (r_qj[r_head] == '0) && (r_qk[r_head] == '0);

  // Surviving entries on flush: the run of committed stores starting at head.
  always_comb begin
    logic          v_run;
    logic [PW-1:0] v_idx;
    w_keep = '0;
    w_kept = '0;
    v_run  = 1'b1;
    v_idx  = r_head;
    for (int unsigned i = 0; i < LSB_SIZE; i++) begin
      v_run = v_run & r_valid[v_idx] & r_is_store[v_idx] & r_committed[v_idx];
      w_keep[v_idx] = v_run;
      w_kept = w_kept + PW'(v_run);
      v_idx  = f_next(v_idx);
    end
  end

  assign w_tsum       = {1'b0, r_head} + {1'b0, w_kept};
  assign w_flush_tail = (w_tsum > SZ_X) ? PW'(w_tsum - SZ_X) : w_tsum[PW-1:0];

  always_comb begin
    w_next_state  = r_state;
    w_issue_load  = 1'b0;
    w_issue_store = 1'b0;
    w_pop         = 1'b0;
    w_bcast       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_head_load_ok) begin
          w_issue_load = 1'b1;
          w_next_state = S_LOAD_WAIT;
        end else if (w_head_store_ok) begin
          w_issue_store = 1'b1;
          w_next_state  = S_STORE_WAIT;
        end
      end
      S_LOAD_WAIT: begin
        if (reset_from_rob_bus) begin
          w_next_state = mem_done ? S_IDLE : S_DRAIN;
        end else if (mem_done) begin
          w_pop        = 1'b1;
          w_bcast      = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_STORE_WAIT: begin
        if (mem_done) begin
          w_pop        = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (mem_done) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (rdy) begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= PW'(1);
      r_tail <= PW'(1);
      r_size <= '0;
      for (int unsigned i = 1; i <= LSB_SIZE; i++) begin
        r_valid[PW'(i)]     <= 1'b0;
        r_is_store[PW'(i)]  <= 1'b0;
        r_committed[PW'(i)] <= 1'b0;
        r_go[PW'(i)]        <= 1'b0;
        r_funct3[PW'(i)]    <= '0;
        r_dest[PW'(i)]      <= '0;
        r_qj[PW'(i)]        <= '0;
        r_qk[PW'(i)]        <= '0;
        r_vj[PW'(i)]        <= '0;
        r_vk[PW'(i)]        <= '0;
        r_imm[PW'(i)]       <= '0;
      end
    end else if (rdy) begin
      for (int unsigned i = 1; i <= LSB_SIZE; i++) begin
        if (r_valid[PW'(i)]) begin
          if (r_qj[PW'(i)] != '0 && r_qj[PW'(i)] == dest_from_rss_bus) begin
            r_qj[PW'(i)] <= '0;
            r_vj[PW'(i)] <= value_from_rss_bus;
          end else if (r_qj[PW'(i)] != '0 && r_qj[PW'(i)] == dest_to_lsb_bus) begin
            r_qj[PW'(i)] <= '0;
            r_vj[PW'(i)] <= value_to_lsb_bus;
          end
          if (r_qk[PW'(i)] != '0 && r_qk[PW'(i)] == dest_from_rss_bus) begin
            r_qk[PW'(i)] <= '0;
            r_vk[PW'(i)] <= value_from_rss_bus;
          end else if (r_qk[PW'(i)] != '0 && r_qk[PW'(i)] == dest_to_lsb_bus) begin
            r_qk[PW'(i)] <= '0;
            r_vk[PW'(i)] <= value_to_lsb_bus;
          end
          if (dest_from_rob_bus != '0 && dest_from_rob_bus == r_dest[PW'(i)]) begin
            if (ls_select_from_rob_bus && r_is_store[PW'(i)])   r_committed[PW'(i)] <= 1'b1;
            if (!ls_select_from_rob_bus && !r_is_store[PW'(i)]) r_go[PW'(i)]        <= 1'b1;
          end
          if (reset_from_rob_bus && !w_keep[PW'(i)]) r_valid[PW'(i)] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= f_next(r_head);
      end
      if (w_enq) begin
        r_valid[r_tail]     <= 1'b1;
        r_is_store[r_tail]  <= is_store_from_issuer;
        r_committed[r_tail] <= 1'b0;
        r_go[r_tail]        <= 1'b0;
        r_funct3[r_tail]    <= funct3_from_issuer;
        r_dest[r_tail]      <= dest_from_issuer;
        r_qj[r_tail]        <= w_qj_hit ? '0 : qj_from_issuer;
        r_qk[r_tail]        <= w_qk_hit ? '0 : qk_from_issuer;
        r_vj[r_tail]        <= w_enq_vj;
        r_vk[r_tail]        <= w_enq_vk;
        r_imm[r_tail]       <= imm_from_issuer;
        r_tail              <= f_next(r_tail);
      end
      if (reset_from_rob_bus) begin
        r_tail <= w_flush_tail;
        r_size <= w_kept - PW'(w_pop);
      end else begin
        r_size <= r_size + PW'(w_enq) - PW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid        <= 1'b0;
      mem_write        <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      mem_width        <= '0;
      dest_to_lsb_bus  <= '0;
      value_to_lsb_bus <= '0;
    end else if (rdy) begin
      mem_valid        <= 1'b0;
      mem_write        <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      mem_width        <= '0;
      dest_to_lsb_bus  <= '0;
      value_to_lsb_bus <= '0;
      if (w_issue_load || w_issue_store) begin
        mem_valid <= 1'b1;
        mem_write <= w_issue_store;
        mem_addr  <= r_vj[r_head] + r_imm[r_head];
        mem_width <= r_funct3[r_head][1:0];
        if (w_issue_store) mem_wdata <= r_vk[r_head];
      end
      if (w_bcast) begin
        dest_to_lsb_bus  <= r_dest[r_head];
        value_to_lsb_bus <= f_ext(r_funct3[r_head], mem_rdata);
      end
    end
  end

endmodule
